id_ex_register: RTL and testbench

Pipeline register between the ID stage (register file, immediate generator, Control) and the EX stage (ALU control, ALU, forwarding muxes) of the 5-stage RISC-V core. It latches the Control bundle and the ID datapath operands each cycle and contains the load-use hazard detector. On a load-use hazard it stalls PC and IF/ID and injects a bubble into EX. It also keeps saturating stall and bubble counters for debug.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/hazard_detection_unit.sv | 27 ++
 rtl/id_ex_register.sv | 125 ++++++++++++
 tb/tb_id_ex_register.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode constants, ALUOp encodings and the Control bundle shared by the pipeline stages.
// Rev 1.0
`default_nettype none

package cpu_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       MemWrite;
    logic       MemRead;
    logic       MemToReg;
    logic [1:0] ALUOp;
    logic       ALUSrc;
    logic       RegWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: combinational load-use detector producing stall, PC write enable and gated flush.
// Rev 1.0
`default_nettype none

module hazard_detection_unit (
  input  logic       ex_MemRead_i,
  input  logic [4:0] ex_RDaddr_i,
  input  logic [4:0] RS1addr_i,
  input  logic [4:0] RS2addr_i,
  input  logic       flush_i,
  output logic       stall_o,
  output logic       PCWrite_o,
  output logic       flush_eff_o
);

  logic rd_match;

  assign rd_match = (ex_RDaddr_i == RS1addr_i) | (ex_RDaddr_i == RS2addr_i);

  // A load into x0 never produces a usable value, so it cannot create a hazard.
  assign stall_o     = ex_MemRead_i & (ex_RDaddr_i != 5'd0) & rd_match;
  assign PCWrite_o   = ~stall_o;
  assign flush_eff_o = flush_i & ~stall_o;

endmodule

`default_nettype wire

// File: rtl/id_ex_register.sv
// id_ex_register: ID/EX pipeline register with load-use bubble injection and saturating debug counters.
// Rev 1.0
`default_nettype none

module id_ex_register
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             MemWrite_i,
  input  logic             MemRead_i,
  input  logic             MemToReg_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             flush_i,
  input  logic [31:0]      RS1data_i,
  input  logic [31:0]      RS2data_i,
  input  logic [31:0]      Imm_i,
  input  logic [9:0]       funct_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic             MemWrite_o,
  output logic             MemRead_o,
  output logic             MemToReg_o,
  output logic             ALUSrc_o,
  output logic             RegWrite_o,
  output logic [1:0]       ALUOp_o,
  output logic [31:0]      RS1data_o,
  output logic [31:0]      RS2data_o,
  output logic [31:0]      Imm_o,
  output logic [9:0]       funct_o,
  output logic [4:0]       RS1addr_o,
  output logic [4:0]       RS2addr_o,
  output logic [4:0]       RDaddr_o,
  output logic             stall_o,
  output logic             PCWrite_o,
  output logic             flush_eff_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t ctrl_in, ctrl_d, ctrl_q;
  logic [31:0] RS1data_q, RS2data_q, Imm_q;
  logic [9:0]  funct_q;
  logic [4:0]  RS1addr_q, RS2addr_q, RDaddr_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q, bubble_cnt_d, bubble_cnt_q;
  logic hazard;

  hazard_detection_unit u_hdu (
    .ex_MemRead_i (ctrl_q.MemRead),
    .ex_RDaddr_i  (RDaddr_q),
    .RS1addr_i    (RS1addr_i),
    .RS2addr_i    (RS2addr_i),
    .flush_i      (flush_i),
    .stall_o      (hazard),
    .PCWrite_o    (PCWrite_o),
    .flush_eff_o  (flush_eff_o)
  );

  assign ctrl_in = '{MemWrite: MemWrite_i, MemRead: MemRead_i, MemToReg: MemToReg_i,
                     ALUOp: ALUOp_i, ALUSrc: ALUSrc_i, RegWrite: RegWrite_i};

  // Only the control bundle is squashed; datapath fields still follow the inputs.
  always_comb begin
    ctrl_d       = hazard ? CTRL_NOP : ctrl_in;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hazard && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (hazard && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q       <= CTRL_NOP;
      RS1data_q    <= '0;
      RS2data_q    <= '0;
      Imm_q        <= '0;
      funct_q      <= '0;
      RS1addr_q    <= '0;
      RS2addr_q    <= '0;
      RDaddr_q     <= '0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      RS1data_q    <= RS1data_i;
      RS2data_q    <= RS2data_i;
      Imm_q        <= Imm_i;
      funct_q      <= funct_i;
      RS1addr_q    <= RS1addr_i;
      RS2addr_q    <= RS2addr_i;
      RDaddr_q     <= RDaddr_i;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign MemWrite_o   = ctrl_q.MemWrite;
  assign MemRead_o    = ctrl_q.MemRead;
  assign MemToReg_o   = ctrl_q.MemToReg;
  assign ALUSrc_o     = ctrl_q.ALUSrc;
  assign RegWrite_o   = ctrl_q.RegWrite;
  assign ALUOp_o      = ctrl_q.ALUOp;
  assign RS1data_o    = RS1data_q;
  assign RS2data_o    = RS2data_q;
  assign Imm_o        = Imm_q;
  assign funct_o      = funct_q;
  assign RS1addr_o    = RS1addr_q;
  assign RS2addr_o    = RS2addr_q;
  assign RDaddr_o     = RDaddr_q;
  assign stall_o      = hazard;
  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_register.sv
// tb_id_ex_register: directed scoreboard bench for id_ex_register built with 4-bit counters.
// Rev 1.0
`default_nettype none

module tb_id_ex_register;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_i;
  logic MemWrite_i, MemRead_i, MemToReg_i, ALUSrc_i, RegWrite_i, flush_i;
  logic [1:0] ALUOp_i;
  logic [31:0] RS1data_i, RS2data_i, Imm_i;
  logic [9:0] funct_i;
  logic [4:0] RS1addr_i, RS2addr_i, RDaddr_i;
  logic MemWrite_o, MemRead_o, MemToReg_o, ALUSrc_o, RegWrite_o;
  logic [1:0] ALUOp_o;
  logic [31:0] RS1data_o, RS2data_o, Imm_o;
  logic [9:0] funct_o;
  logic [4:0] RS1addr_o, RS2addr_o, RDaddr_o;
  logic stall_o, PCWrite_o, flush_eff_o;
  logic [CW-1:0] stall_cnt_o, bubble_cnt_o;

  always #5 clk = ~clk;

  id_ex_register #(.CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i), .MemToReg_i(MemToReg_i),
    .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i), .flush_i(flush_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .Imm_i(Imm_i), .funct_i(funct_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .MemWrite_o(MemWrite_o), .MemRead_o(MemRead_o), .MemToReg_o(MemToReg_o),
    .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o), .ALUOp_o(ALUOp_o),
    .RS1data_o(RS1data_o), .RS2data_o(RS2data_o), .Imm_o(Imm_o), .funct_o(funct_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .stall_o(stall_o), .PCWrite_o(PCWrite_o), .flush_eff_o(flush_eff_o),
    .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
  );

  typedef struct packed {
    logic mw, mr, mtr, alusrc, rw;
    logic [1:0] aluop;
    logic [31:0] d1, d2, imm;
    logic [9:0] funct;
    logic [4:0] a1, a2, rd;
  } regs_t;

  typedef struct packed {
    regs_t regs;
    logic [CW-1:0] sc, bc;
  } exp_t;

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference state, maintained independently of the DUT.
  logic m_valid = 1'b0;
  logic m_mr = 1'b0;
  logic [4:0] m_rd = 5'd0;
  logic [CW-1:0] m_sc = '0, m_bc = '0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one ID-stage instruction for one cycle; we enter just after a falling edge.
  task automatic step(input string tag, input logic rst,
                      input logic mw, mr, mtr, alusrc, rw, input logic [1:0] aluop,
                      input logic [31:0] imm, input logic [9:0] f,
                      input logic [4:0] a1, a2, rd, input logic fl);
    logic hz;
    exp_t e, o;
    rst_i = rst; MemWrite_i = mw; MemRead_i = mr; MemToReg_i = mtr; ALUSrc_i = alusrc;
    RegWrite_i = rw; ALUOp_i = aluop; Imm_i = imm; funct_i = f;
    RS1addr_i = a1; RS2addr_i = a2; RDaddr_i = rd; flush_i = fl;
    RS1data_i = $urandom; RS2data_i = $urandom;
    #1;
    hz = m_mr && (m_rd != 5'd0) && ((m_rd == a1) || (m_rd == a2));
    if (m_valid) begin
      check1({tag, "/stall"}, stall_o, hz);
      check1({tag, "/pcwrite"}, PCWrite_o, ~hz);
      check1({tag, "/flush_eff"}, flush_eff_o, fl & ~hz);
    end
    if (rst) begin
      e = '0;
    end else begin
      e.regs = '{mw: hz ? 1'b0 : mw, mr: hz ? 1'b0 : mr, mtr: hz ? 1'b0 : mtr,
                 alusrc: hz ? 1'b0 : alusrc, rw: hz ? 1'b0 : rw,
                 aluop: hz ? 2'b00 : aluop, d1: RS1data_i, d2: RS2data_i, imm: imm,
                 funct: f, a1: a1, a2: a2, rd: rd};
      e.sc = (hz && m_sc != '1) ? m_sc + 1'b1 : m_sc;
      e.bc = (hz && m_bc != '1) ? m_bc + 1'b1 : m_bc;
    end
    sb_q.push_back(e);
    m_valid = 1'b1; m_mr = e.regs.mr; m_rd = e.regs.rd; m_sc = e.sc; m_bc = e.bc;
    @(posedge clk); #1;
    e = sb_q.pop_front();
    o.regs = '{mw: MemWrite_o, mr: MemRead_o, mtr: MemToReg_o, alusrc: ALUSrc_o,
               rw: RegWrite_o, aluop: ALUOp_o, d1: RS1data_o, d2: RS2data_o, imm: Imm_o,
               funct: funct_o, a1: RS1addr_o, a2: RS2addr_o, rd: RDaddr_o};
    o.sc = stall_cnt_o; o.bc = bubble_cnt_o;
    n_cmp++;
    assert (o.regs === e.regs) else begin
      n_err++;
      $error("FAIL %s/regs observed=%h expected=%h", tag, o.regs, e.regs);
    end
    n_cmp++;
    assert ({o.sc, o.bc} === {e.sc, e.bc}) else begin
      n_err++;
      $error("FAIL %s/counters observed stall=%0d bubble=%0d expected stall=%0d bubble=%0d",
             tag, o.sc, o.bc, e.sc, e.bc);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    // Reset with every input nonzero.
    step("reset0", 1'b1, 1,1,1,1,1, 2'b11, 32'hFFFF_FFFF, 10'h3FF, 5'd5, 5'd5, 5'd5, 1'b1);
    step("reset1", 1'b1, 1,1,1,1,1, 2'b11, 32'hFFFF_FFFF, 10'h3FF, 5'd5, 5'd5, 5'd5, 1'b1);
    check1("reset/pcwrite_idle", PCWrite_o, 1'b1);

    // addi x3, x1, 5
    step("addi", 1'b0, 0,0,0,1,1, 2'b00, 32'h0000_0005, 10'h000, 5'd1, 5'd5, 5'd3, 1'b0);
    // lw x5 then add x6, x5, x7 (bubble), add held in ID (normal load)
    step("lw_x5", 1'b0, 0,1,1,1,1, 2'b00, 32'h0000_0010, 10'h002, 5'd2, 5'd0, 5'd5, 1'b0);
    step("add_stall", 1'b0, 0,0,0,0,1, 2'b10, 32'h0, 10'h000, 5'd5, 5'd7, 5'd6, 1'b0);
    step("add_retry", 1'b0, 0,0,0,0,1, 2'b10, 32'h0, 10'h000, 5'd5, 5'd7, 5'd6, 1'b0);
    // Load into x0 followed by a reader of x0
    step("lw_x0", 1'b0, 0,1,1,1,1, 2'b00, 32'h0000_0004, 10'h002, 5'd2, 5'd0, 5'd0, 1'b0);
    step("rd_x0", 1'b0, 0,0,0,0,1, 2'b10, 32'h0, 10'h000, 5'd0, 5'd0, 5'd8, 1'b0);
    // lw x1 then beq x1, x2 with a flush request
    step("lw_x1", 1'b0, 0,1,1,1,1, 2'b00, 32'h0000_0008, 10'h002, 5'd3, 5'd0, 5'd1, 1'b0);
    step("beq_stall", 1'b0, 0,0,0,0,0, 2'b01, 32'hFFFF_FFF8, 10'h000, 5'd1, 5'd2, 5'd0, 1'b1);
    step("beq_go", 1'b0, 0,0,0,0,0, 2'b01, 32'hFFFF_FFF8, 10'h000, 5'd1, 5'd2, 5'd0, 1'b1);
    // Store of a loaded register as rs2 exercises the RS2 comparator.
    step("lw_x9", 1'b0, 0,1,1,1,1, 2'b00, 32'h0, 10'h002, 5'd4, 5'd0, 5'd9, 1'b0);
    step("sw_stall", 1'b0, 1,0,0,1,0, 2'b00, 32'h0000_000C, 10'h002, 5'd4, 5'd9, 5'd12, 1'b0);
    step("sw_retry", 1'b0, 1,0,0,1,0, 2'b00, 32'h0000_000C, 10'h002, 5'd4, 5'd9, 5'd12, 1'b0);

    // 17 more load-use pairs drive both 4-bit counters into saturation.
    for (int i = 0; i < 17; i++) begin
      step("sat_lw", 1'b0, 0,1,1,1,1, 2'b00, 32'h0, 10'h002, 5'd2, 5'd0, 5'd5, 1'b0);
      step("sat_use", 1'b0, 0,0,0,0,1, 2'b10, 32'h0, 10'h000, 5'd5, 5'd7, 5'd6, 1'b0);
      step("sat_retry", 1'b0, 0,0,0,0,1, 2'b10, 32'h0, 10'h000, 5'd5, 5'd7, 5'd6, 1'b0);
    end
    check1("sat/stall_cnt_full", (stall_cnt_o == 4'hF), 1'b1);
    check1("sat/bubble_cnt_full", (bubble_cnt_o == 4'hF), 1'b1);

    // Reset coinciding with a hazard: reset wins, no increment.
    step("lw_pre_rst", 1'b0, 0,1,1,1,1, 2'b00, 32'h0, 10'h002, 5'd2, 5'd0, 5'd5, 1'b0);
    step("rst_hazard", 1'b1, 0,0,0,0,1, 2'b10, 32'h0, 10'h000, 5'd5, 5'd7, 5'd6, 1'b0);
    step("post_rst", 1'b0, 0,0,0,1,1, 2'b00, 32'h0000_0001, 10'h000, 5'd5, 5'd0, 5'd5, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete within time budget");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
